// File: rtl/sync_controller_pkg.sv
// Shared definitions for the sync acquisition / lock-tracking controller.
// Contents:
//   - counter and index widths
//   - FSM state encodings
//   - deperforator state count by code rate
//   - saturating increment helper for the 4-bit hysteresis counters
package sync_ctrl_pkg;

   localparam int CNT_W    = 4;   // confirm / miss / settle counters
   localparam int PHASE_W  = 2;   // LLR phase hypothesis index
   localparam int DEPERF_W = 3;   // deperforator hypothesis index

   typedef logic [1:0] sync_state_t;

   localparam logic [1:0] ST_SEARCH   = 2'd0;
   localparam logic [1:0] ST_CONFIRM  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;
   localparam logic [1:0] ST_FLYWHEEL = 2'd3;

   // Number of deperforator hypotheses for a given code rate.
   function automatic logic [DEPERF_W-1:0] deperf_states(input logic [1:0] code_rate);
      logic [DEPERF_W-1:0] d;
      case (code_rate)
         2'd0:    d = 3'd1;
         2'd1:    d = 3'd2;
         2'd2:    d = 3'd3;
         default: d = 3'd7;
      endcase
      return d;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_controller_hypothesis_stepper.sv
// Hypothesis stepper: walks the LLR phase index first, then the deperforator
// index, one position per step request.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             synchronous return of both indexes to 0, no pulses
//   step              one-cycle request to advance to the next hypothesis
//   code_rate         selects the deperforator hypothesis count
//   next_phase        one-cycle kick to the LLR former
//   deperf_next       one-cycle kick to the deperforator
//   sweep_done        one-cycle pulse when the deperforator index wraps to 0
//   phase_idx         current phase hypothesis
//   deperf_idx        current deperforator hypothesis
module hypothesis_stepper
   import sync_ctrl_pkg::*;
#(
   parameter int NUM_PHASES = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                step,
   input  logic [1:0]          code_rate,
   output logic                next_phase,
   output logic                deperf_next,
   output logic                sweep_done,
   output logic [PHASE_W-1:0]  phase_idx,
   output logic [DEPERF_W-1:0] deperf_idx
);

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

   logic [DEPERF_W:0] deperf_inc;
   logic              deperf_wrap;

   // One extra bit so the compare against the state count cannot overflow.
   assign deperf_inc  = {1'b0, deperf_idx} + (DEPERF_W+1)'(1);
   assign deperf_wrap = deperf_inc >= {1'b0, deperf_states(code_rate)};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         next_phase  <= 1'b0;
         deperf_next <= 1'b0;
         sweep_done  <= 1'b0;
         phase_idx   <= '0;
         deperf_idx  <= '0;
      end else begin
         next_phase  <= 1'b0;
         deperf_next <= 1'b0;
         sweep_done  <= 1'b0;
         if (clear) begin
            phase_idx  <= '0;
            deperf_idx <= '0;
         end else if (step) begin
            if (phase_idx < LAST_PHASE) begin
               phase_idx  <= phase_idx + PHASE_W'(1);
               next_phase <= 1'b1;
            end else begin
               phase_idx   <= '0;
               deperf_next <= 1'b1;
               if (deperf_wrap) begin
                  deperf_idx <= '0;
                  sweep_done <= 1'b1;
               end else begin
                  deperf_idx <= deperf_inc[DEPERF_W-1:0];
               end
            end
         end
      end
   end

endmodule

// File: rtl/sync_controller.sv
// Sync acquisition and lock-tracking controller. Judges each measurement
// period's error count, runs SEARCH/CONFIRM/LOCKED/FLYWHEEL with confirm and
// miss hysteresis, and requests hypothesis steps followed by a settle blanking.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   i_enable             0 holds everything in SEARCH / zero
//   i_code_rate          deperforator state count select; a change restarts
//   i_period_vld         end-of-period strobe
//   i_err_cnt            error count of the finished period
//   i_lock_thr           period is good when i_err_cnt < i_lock_thr
//   i_confirm_num        good periods needed to lock (0 acts as 1)
//   i_miss_num           bad periods in lock needed to drop it (0 acts as 1)
//   i_settle_num         strobes ignored after each step
//   o_next_phase         kick to LLR former
//   o_deperf_next_st     kick to deperforator
//   o_sweep_done         full sweep exhausted without lock
//   o_is_sync            high in LOCKED or FLYWHEEL
//   o_phase_idx          current phase hypothesis
//   o_deperf_idx         current deperforator hypothesis
//   o_state              FSM state
module sync_controller
   import sync_ctrl_pkg::*;
#(
   parameter int SYNC_PERIOD_WIDTH = 24,
   parameter int NUM_PHASES        = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         i_enable,
   input  logic [1:0]                   i_code_rate,
   input  logic                         i_period_vld,
   input  logic [SYNC_PERIOD_WIDTH-1:0] i_err_cnt,
   input  logic [SYNC_PERIOD_WIDTH-1:0] i_lock_thr,
   input  logic [3:0]                   i_confirm_num,
   input  logic [3:0]                   i_miss_num,
   input  logic [3:0]                   i_settle_num,
   output logic                         o_next_phase,
   output logic                         o_deperf_next_st,
   output logic                         o_sweep_done,
   output logic                         o_is_sync,
   output logic [1:0]                   o_phase_idx,
   output logic [2:0]                   o_deperf_idx,
   output logic [1:0]                   o_state
);

   sync_state_t      state_reg, state_next;
   logic [CNT_W-1:0] good_reg, good_next;
   logic [CNT_W-1:0] miss_reg, miss_next;
   logic [CNT_W-1:0] settle_reg, settle_next;
   logic [1:0]       rate_reg;
   logic             rate_change, clear, good, step;
   logic [CNT_W-1:0] confirm_eff, miss_eff, good_inc, miss_inc;

   assign rate_change = i_code_rate != rate_reg;
   assign clear       = rate_change || !i_enable;
   assign good        = i_err_cnt < i_lock_thr;
   assign confirm_eff = (i_confirm_num == '0) ? CNT_W'(1) : i_confirm_num;
   assign miss_eff    = (i_miss_num == '0) ? CNT_W'(1) : i_miss_num;
   assign good_inc    = sat_inc(good_reg);
   assign miss_inc    = sat_inc(miss_reg);

   always_comb begin
      state_next  = state_reg;
      good_next   = good_reg;
      miss_next   = miss_reg;
      settle_next = settle_reg;
      step        = 1'b0;
      if (clear) begin
         state_next  = ST_SEARCH;
         good_next   = '0;
         miss_next   = '0;
         settle_next = '0;
      end else if (i_period_vld && settle_reg != '0) begin
         // Blanking after a step: the strobe only counts down.
         settle_next = settle_reg - CNT_W'(1);
      end else if (i_period_vld) begin
         case (state_reg)
            ST_SEARCH: begin
               if (good) begin
                  good_next  = CNT_W'(1);
                  state_next = (confirm_eff == CNT_W'(1)) ? ST_LOCKED : ST_CONFIRM;
               end else begin
                  step = 1'b1;
               end
            end
            ST_CONFIRM: begin
               if (good) begin
                  good_next = good_inc;
                  if (good_inc >= confirm_eff) state_next = ST_LOCKED;
               end else begin
                  step       = 1'b1;
                  good_next  = '0;
                  state_next = ST_SEARCH;
               end
            end
            ST_LOCKED: begin
               if (!good) begin
                  if (miss_eff == CNT_W'(1)) begin
                     miss_next  = '0;
                     state_next = ST_SEARCH;
                  end else begin
                     miss_next  = CNT_W'(1);
                     state_next = ST_FLYWHEEL;
                  end
               end
            end
            default: begin   // ST_FLYWHEEL
               if (good) begin
                  miss_next  = '0;
                  state_next = ST_LOCKED;
               end else if (miss_inc >= miss_eff) begin
                  // Lock lost: re-evaluate the current hypothesis before stepping.
                  miss_next  = '0;
                  state_next = ST_SEARCH;
               end else begin
                  miss_next = miss_inc;
               end
            end
         endcase
         if (state_next != ST_CONFIRM) good_next = (state_next == ST_SEARCH || state_next == ST_LOCKED) ? '0 : good_next;
         if (step) settle_next = i_settle_num;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ST_SEARCH;
         good_reg   <= '0;
         miss_reg   <= '0;
         settle_reg <= '0;
         rate_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         good_reg   <= good_next;
         miss_reg   <= miss_next;
         settle_reg <= settle_next;
         rate_reg   <= i_code_rate;
      end
   end

   hypothesis_stepper #(
      .NUM_PHASES (NUM_PHASES)
   ) u_stepper (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .step        (step),
      .code_rate   (i_code_rate),
      .next_phase  (o_next_phase),
      .deperf_next (o_deperf_next_st),
      .sweep_done  (o_sweep_done),
      .phase_idx   (o_phase_idx),
      .deperf_idx  (o_deperf_idx)
   );

   assign o_state   = state_reg;
   assign o_is_sync = (state_reg == ST_LOCKED) || (state_reg == ST_FLYWHEEL);

endmodule

// File: tb/tb_sync_controller.sv
// Self-checking bench for sync_controller: a behavioural model predicts the
// registered outputs for each driven cycle, pushes them to a scoreboard queue,
// and the entry is popped and compared one edge later.
module tb_sync_controller;

   localparam int W  = 24;
   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_enable;
   logic [1:0]    i_code_rate;
   logic          i_period_vld;
   logic [W-1:0]  i_err_cnt;
   logic [W-1:0]  i_lock_thr;
   logic [3:0]    i_confirm_num;
   logic [3:0]    i_miss_num;
   logic [3:0]    i_settle_num;
   logic          o_next_phase, o_deperf_next_st, o_sweep_done, o_is_sync;
   logic [1:0]    o_phase_idx;
   logic [2:0]    o_deperf_idx;
   logic [1:0]    o_state;

   sync_controller #(.SYNC_PERIOD_WIDTH(W), .NUM_PHASES(NP)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_enable         (i_enable),
      .i_code_rate      (i_code_rate),
      .i_period_vld     (i_period_vld),
      .i_err_cnt        (i_err_cnt),
      .i_lock_thr       (i_lock_thr),
      .i_confirm_num    (i_confirm_num),
      .i_miss_num       (i_miss_num),
      .i_settle_num     (i_settle_num),
      .o_next_phase     (o_next_phase),
      .o_deperf_next_st (o_deperf_next_st),
      .o_sweep_done     (o_sweep_done),
      .o_is_sync        (o_is_sync),
      .o_phase_idx      (o_phase_idx),
      .o_deperf_idx     (o_deperf_idx),
      .o_state          (o_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st; int ph; int dp; int np; int dn; int sd; int sy;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   txn      = 0;

   // Model state
   int m_state, m_good, m_miss, m_settle, m_phase, m_deperf, m_rate;
   int d_tab[4] = '{1, 2, 3, 7};

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic m_reset();
      m_state = 0; m_good = 0; m_miss = 0; m_settle = 0;
      m_phase = 0; m_deperf = 0; m_rate = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ".state"},  int'(o_state), 0);
      check_val({tag, ".phase"},  int'(o_phase_idx), 0);
      check_val({tag, ".deperf"}, int'(o_deperf_idx), 0);
      check_val({tag, ".np"},     int'(o_next_phase), 0);
      check_val({tag, ".dn"},     int'(o_deperf_next_st), 0);
      check_val({tag, ".sd"},     int'(o_sweep_done), 0);
      check_val({tag, ".sync"},   int'(o_is_sync), 0);
   endtask

   // Drive one cycle (strobe or idle), predict, then compare after the edge.
   task automatic cycle(input logic vld, input logic [W-1:0] err, input logic [1:0] rate);
      exp_t e;
      int   conf, miss;
      bit   good, step;
      @(negedge clk);
      i_period_vld = vld;
      i_err_cnt    = err;
      i_code_rate  = rate;
      e.np = 0; e.dn = 0; e.sd = 0;
      step = 0;
      conf = (i_confirm_num == 0) ? 1 : int'(i_confirm_num);
      miss = (i_miss_num == 0) ? 1 : int'(i_miss_num);
      good = err < i_lock_thr;
      if (int'(rate) != m_rate || !i_enable) begin
         m_state = 0; m_good = 0; m_miss = 0; m_settle = 0; m_phase = 0; m_deperf = 0;
      end else if (vld) begin
         if (m_settle > 0) m_settle--;
         else if (m_state == 0) begin
            if (good) begin m_good = 1; m_state = (conf == 1) ? 2 : 1; end
            else step = 1;
         end else if (m_state == 1) begin
            if (good) begin
               if (m_good < 15) m_good++;
               if (m_good >= conf) m_state = 2;
            end else begin step = 1; m_state = 0; m_good = 0; end
         end else if (m_state == 2) begin
            if (!good) begin
               if (miss == 1) m_state = 0;
               else begin m_miss = 1; m_state = 3; end
            end
         end else begin
            if (good) begin m_miss = 0; m_state = 2; end
            else begin
               if (m_miss < 15) m_miss++;
               if (m_miss >= miss) begin m_miss = 0; m_state = 0; end
            end
         end
         if (step) begin
            m_settle = int'(i_settle_num);
            if (m_phase < NP - 1) begin m_phase++; e.np = 1; end
            else begin
               m_phase = 0; e.dn = 1;
               m_deperf++;
               if (m_deperf >= d_tab[rate]) begin m_deperf = 0; e.sd = 1; end
            end
         end
      end
      m_rate = int'(rate);
      e.st = m_state; e.ph = m_phase; e.dp = m_deperf;
      e.sy = (m_state >= 2) ? 1 : 0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      i_period_vld = 1'b0;
      e = sb_q.pop_front();
      txn++;
      $display("txn %0d vld=%0d err=%0d rate=%0d -> state=%0d ph=%0d dp=%0d np=%0d dn=%0d sd=%0d",
               txn, vld, err, rate, o_state, o_phase_idx, o_deperf_idx,
               o_next_phase, o_deperf_next_st, o_sweep_done);
      check_val("state",  int'(o_state), e.st);
      check_val("phase",  int'(o_phase_idx), e.ph);
      check_val("deperf", int'(o_deperf_idx), e.dp);
      check_val("np",     int'(o_next_phase), e.np);
      check_val("dn",     int'(o_deperf_next_st), e.dn);
      check_val("sd",     int'(o_sweep_done), e.sd);
      check_val("sync",   int'(o_is_sync), e.sy);
   endtask

   initial begin
      reset_n       = 1'b0;
      i_enable      = 1'b1;
      i_code_rate   = 2'd0;
      i_period_vld  = 1'b0;
      i_err_cnt     = '0;
      i_lock_thr    = W'(10);
      i_confirm_num = 4'd3;
      i_miss_num    = 4'd3;
      i_settle_num  = 4'd0;
      m_reset();
      #1;
      check_all_zero("reset");
      #20;
      @(negedge clk);
      reset_n = 1'b1;

      // Acquire: three good periods with confirm_num=3.
      repeat (3) cycle(1'b1, W'(5), 2'd0);
      // Flywheel and recover, then lose lock without a step.
      cycle(1'b1, W'(20), 2'd0);
      cycle(1'b1, W'(20), 2'd0);
      cycle(1'b1, W'(5),  2'd0);
      repeat (3) cycle(1'b1, W'(20), 2'd0);
      cycle(1'b0, W'(0), 2'd0);

      // Rate 1 (D=2): rate change clears, then a full bad sweep of 8 steps.
      cycle(1'b0, W'(0), 2'd1);
      repeat (8) cycle(1'b1, W'(20), 2'd1);

      // Settle blanking of 2 strobes.
      i_settle_num = 4'd2;
      cycle(1'b1, W'(20), 2'd1);
      cycle(1'b1, W'(5),  2'd1);
      cycle(1'b1, W'(5),  2'd1);
      cycle(1'b1, W'(5),  2'd1);
      i_settle_num = 4'd0;

      // Rate change mid-CONFIRM with same-cycle strobe, then 28-step sweep at rate 3.
      cycle(1'b1, W'(5), 2'd3);
      repeat (28) cycle(1'b1, W'(20), 2'd3);

      // Threshold boundaries.
      i_lock_thr = '0;
      cycle(1'b1, W'(0), 2'd3);
      i_lock_thr = '1;
      cycle(1'b1, '1, 2'd3);
      cycle(1'b1, W'(24'hFFFFFE), 2'd3);
      // confirm_num=0 and miss_num=0 act as 1.
      i_confirm_num = 4'd0;
      i_miss_num    = 4'd0;
      cycle(1'b1, W'(3), 2'd3);
      i_lock_thr = W'(10);
      cycle(1'b1, W'(20), 2'd3);
      cycle(1'b1, W'(5), 2'd3);
      cycle(1'b1, W'(20), 2'd3);
      i_confirm_num = 4'd3;
      i_miss_num    = 4'd3;

      // Enable low clears with a same-cycle strobe.
      cycle(1'b1, W'(20), 2'd3);
      i_enable = 1'b0;
      cycle(1'b1, W'(20), 2'd3);
      i_enable = 1'b1;

      // Asynchronous reset while a kick is high.
      cycle(1'b1, W'(20), 2'd3);
      check_val("kick_before_reset", int'(o_next_phase), 1);
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
